// File: rtl/dec_imp.sv
// 3-to-8 decoder with registered one-hot lines plus adder sum/carry and subtractor borrow
// built from decoder minterms; 1-cycle latency, accepts a new index every clock.
module dec_imp #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic f1,
  output logic f2,
  output logic f3
);

  logic [2:0] idx;
  logic [7:0] dec;
  logic       sum_nxt;
  logic       carry_nxt;
  logic       borrow_nxt;

  assign idx = {a, b, c};

  always_comb begin
    dec = 8'b0;
    dec[idx] = 1'b1;
  end

  // Functions use the live decode so d and f always land on the same edge.
  assign sum_nxt    = dec[1] | dec[2] | dec[4] | dec[7];
  assign carry_nxt  = dec[3] | dec[5] | dec[6] | dec[7];
  assign borrow_nxt = dec[1] | dec[2] | dec[3] | dec[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      {d7, d6, d5, d4, d3, d2, d1, d0} <= {8{RESET_VAL}};
      f1 <= RESET_VAL;
      f2 <= RESET_VAL;
      f3 <= RESET_VAL;
    end else begin
      {d7, d6, d5, d4, d3, d2, d1, d0} <= dec;
      f1 <= sum_nxt;
      f2 <= carry_nxt;
      f3 <= borrow_nxt;
    end
  end

endmodule

// File: tb/tb_dec_imp.sv
// Scoreboard bench for dec_imp: expected vectors queued at drive time, popped after each edge.
module tb_dec_imp;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic c;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic f1, f2, f3;

  int n_cmp;
  int n_fail;
  logic [10:0] sb_q[$];

  dec_imp #(.RESET_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .f1(f1), .f2(f2), .f3(f3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {d7..d0, f1, f2, f3}
  wire [10:0] obs = {d7, d6, d5, d4, d3, d2, d1, d0, f1, f2, f3};

  function automatic logic [10:0] model(input logic ra, input logic rb, input logic rc,
                                        input logic rr);
    logic [7:0] d;
    logic s, cy, bw;
    if (rr) return 11'b0;
    d  = 8'b1 << {ra, rb, rc};
    s  = ra ^ rb ^ rc;
    cy = (ra & rb) | (ra & rc) | (rb & rc);
    bw = (~ra & (rb | rc)) | (rb & rc);
    return {d, s, cy, bw};
  endfunction

  task automatic drive(input logic ra, input logic rb, input logic rc, input logic rr);
    a = ra;
    b = rb;
    c = rc;
    rst = rr;
    sb_q.push_back(model(ra, rb, rc, rr));
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, exp);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp || obs !== 11'b10000000_111) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_sweep();
    logic [10:0] exp;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b0);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sweep idx=%0d: got %b want %b", i, obs, exp);
      end
    end
    // Spot-check two truth-table rows against literal constants.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    n_cmp++;
    if (obs !== 11'b00001000_011) begin
      n_fail++;
      $display("FAIL sweep_idx3_const: got %b want %b", obs, 11'b00001000_011);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    n_cmp++;
    if (obs !== 11'b00010000_100) begin
      n_fail++;
      $display("FAIL sweep_idx4_const: got %b want %b", obs, 11'b00010000_100);
    end
  endtask

  task automatic test_latency();
    logic [10:0] exp0, exp5;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp0 = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp0) begin
      n_fail++;
      $display("FAIL latency_idx0: got %b want %b", obs, exp0);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    // Also pulse rst mid-cycle; it must not act before the edge.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    n_cmp++;
    if (obs !== exp0) begin
      n_fail++;
      $display("FAIL latency_hold: got %b want %b", obs, exp0);
    end
    @(posedge clk); #1;
    exp5 = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp5 || obs !== 11'b00100000_010) begin
      n_fail++;
      $display("FAIL latency_idx5: got %b want %b", obs, exp5);
    end
  endtask

  task automatic test_midstream_reset();
    logic [10:0] exp;
    logic [2:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b0);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_sweep idx=%0d: got %b want %b", i, obs, exp);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want %b", obs, exp);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp || obs !== 11'b00000100_101) begin
      n_fail++;
      $display("FAIL mid_release_idx2: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_glitch();
    logic [10:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      #2 a = 1'b1;
      #3 a = 1'b0;
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp || obs !== 11'b00001000_011) begin
        n_fail++;
        $display("FAIL glitch[%0d]: got %b want %b", i, obs, exp);
      end
      #2 a = 1'b1;
      #1;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch_between[%0d]: got %b want %b", i, obs, exp);
      end
      a = 1'b0;
      @(negedge clk); @(posedge clk); #1;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL glitch_idle[%0d]: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    logic [2:0] v;
    for (int i = 0; i < 200; i++) begin
      v = 3'($urandom_range(0, 7));
      drive(v[2], v[1], v[0], 1'b0);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] idx=%0d: got %b want %b", i, v, obs, exp);
      end
      n_cmp++;
      if ($countones(obs[10:3]) != 1) begin
        n_fail++;
        $display("FAIL onehot[%0d]: got popcount %0d want 1", i, $countones(obs[10:3]));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_latency();
    test_midstream_reset();
    test_glitch();
    test_random();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
